uart_byte_rx: RTL
=================

Name: uart_byte_rx

Overview:
- Serial receive front end sitting directly upstream of the terminal data-storage stage.
- Oversamples the asynchronous RX line and assembles 8N1 frames, LSB first.
- Presents each good byte on numRx with a one-cycle rxDataRdy strobe, which is the storage stage's write request.
- Can defer delivery while the storage stage reports busy, holding one byte; reports framing errors and overruns.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- OVERSAMPLE, 16, sample ticks per bit; must be an even value of at least 4.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset; 0 = reset.
- rx  in  1  asynchronous serial line, idle high.
- hold  in  1  downstream busy (storage stage busy flag); 1 = do not strobe.
- numRx  out  8  received byte; stable from strobe until the next strobe.
- rxDataRdy  out  1  one-cycle strobe: numRx valid.
- framingErr  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte dropped because one was already pending.

Behaviour:
- Reset (reset=0 at a clk edge):
  - numRx=0, rxDataRdy=0, framingErr=0, overrun=0.
  - pending=0, state=IDLE, both sync flops=1, all counters=0.
  - Reset mid-frame aborts the frame without any output pulse.
- Input sync: rx passes through two flops before any use; rx_s denotes the second flop.
- Tick generator:
  - DIV = CLK_HZ/(BAUD*OVERSAMPLE), integer division, minimum 1.
  - Counter counts 0..DIV-1; tick is high for one cycle at wrap.
  - Counter is cleared on entry to START so sampling phase is aligned to the start edge.
- Frame state machine (all counts below are in ticks):
  - IDLE: when rx_s=0, go to START with sample count sc=0.
  - START: on each tick sc++. At sc=OVERSAMPLE/2-1 (mid start bit):
    - rx_s=0 → go to DATA, sc=0, bit index bi=0.
    - rx_s=1 → glitch; return to IDLE with no pulse.
  - DATA: on each tick sc++. At sc=OVERSAMPLE-1, shift rx_s into the shift register MSB (LSB-first assembly), sc=0, bi++. After bi=7 is sampled, go to STOP.
  - STOP: sample at sc=OVERSAMPLE-1.
    - rx_s=1 → byte complete; go to IDLE.
    - rx_s=0 → framingErr pulse next cycle, byte discarded; go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. A held-low line produces exactly one framingErr per break.
- Delivery (byte-complete event):
  - hold=0 and pending=0: next cycle numRx=shift register and rxDataRdy=1 for exactly one cycle.
  - hold=1 and pending=0: store the byte in the pending register, pending=1. On the first cycle with hold=0, numRx=pending byte, rxDataRdy=1 for one cycle, pending=0.
  - pending=1 already (whatever hold is): the new byte is dropped, overrun pulses one cycle, and the pending byte is preserved.
  - Byte complete in the same cycle that pending drains: the drain takes priority and the new byte becomes pending (or is delivered next cycle if hold=0). No overrun is raised.
- rxDataRdy is never asserted on two consecutive cycles. numRx changes only together with rxDataRdy.
- Latency from the mid-stop-bit sample to the strobe: 1 clk when hold=0; the sync flops add 2 clk on the line side.

Decomposition:
- Shared package holds:
  - the state enum: IDLE, START, DATA, STOP, BREAK;
  - a function computing DIV from CLK_HZ, BAUD and OVERSAMPLE.
- One natural sub-module: uart_baud_tick (divider with synchronous clear, tick output), reusable by a future transmitter.

Test Plan:
- Bench parameters for all scenarios: CLK_HZ=1600000, BAUD=100000, OVERSAMPLE=16, giving DIV=1 and 16 clk per bit.
- Send 0x41 with hold=0 → exactly one rxDataRdy pulse with numRx=0x41, 3 clk after the mid-stop sample (2 sync + 1); no framingErr or overrun.
- Back-to-back 0x00, 0xFF, 0xA5 with no idle gap → three strobes carrying those values in order, each strobe a single cycle.
- Hold high, send 0x31 then 0x32, release hold 5 clk later:
  - overrun pulses once, at the completion of 0x32;
  - after release, one strobe with numRx=0x31;
  - 0x32 is never delivered.
- Glitch: rx low for 4 clk, then high → no strobe, no error; state returns to IDLE; a following 0x55 is received correctly.
- Stop bit forced low on 0x7E, line held low for 100 clk, then idle:
  - one framingErr pulse, no rxDataRdy;
  - the next frame 0x0D is received correctly.
- Assert reset=0 midway through the data bits of 0x99 → all outputs 0, no strobe; after release, 0x12 is received correctly.

Source files
------------

// File: rtl/uart_byte_rx_pkg.sv
// Shared types and helpers for the UART byte receiver and its baud tick divider.
package uart_byte_rx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rxState_t;

    // Clocks per oversample tick; never below one so the divider always advances.
    function automatic int calcDiv(input int clkHz, input int baud, input int overSample);
        int d;
        d = clkHz / (baud * overSample);
        if (d < 1) d = 1;
        return d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks, with synchronous clear.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: oversampled frame FSM plus a one-byte deferral buffer for a busy consumer.
module uart_byte_rx
    import uart_byte_rx_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       hold,
    output logic [7:0] numRx,
    output logic       rxDataRdy,
    output logic       framingErr,
    output logic       overrun,
    output logic [2:0] dbgState
);

    localparam int DIV = calcDiv(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam logic [SCW-1:0] SC_MID  = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);

    rxState_t       state, stateNext;
    logic [SCW-1:0] sc, scNext;
    logic [2:0]     bi, biNext;
    logic [7:0]     shreg, shregNext;
    logic           rxMeta, rxS;
    logic           tick, tickClr;
    logic           byteDone, frameBad;
    logic           pending, drain;
    logic [7:0]     pendByte;

    uart_baud_tick #(.DIV(DIV)) uBaudTick (
        .clk   (clk),
        .reset (reset),
        .clear (tickClr),
        .tick  (tick)
    );

    assign dbgState = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rxMeta <= 1'b1;
            rxS    <= 1'b1;
            state  <= IDLE;
            sc     <= '0;
            bi     <= '0;
            shreg  <= '0;
        end else begin
            rxMeta <= rx;
            rxS    <= rxMeta;
            state  <= stateNext;
            sc     <= scNext;
            bi     <= biNext;
            shreg  <= shregNext;
        end
    end

    always_comb begin
        stateNext = state;
        scNext    = sc;
        biNext    = bi;
        shregNext = shreg;
        tickClr   = 1'b0;
        byteDone  = 1'b0;
        frameBad  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxS) begin
                    stateNext = START;
                    scNext    = '0;
                    tickClr   = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (sc == SC_MID) begin
                        scNext    = '0;
                        biNext    = '0;
                        stateNext = rxS ? IDLE : DATA;
                    end else begin
                        scNext = sc + SCW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (sc == SC_LAST) begin
                        shregNext = {rxS, shreg[7:1]};
                        scNext    = '0;
                        biNext    = bi + 3'd1;
                        if (bi == 3'd7) stateNext = STOP;
                    end else begin
                        scNext = sc + SCW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (sc == SC_LAST) begin
                        scNext = '0;
                        if (rxS) begin
                            byteDone  = 1'b1;
                            stateNext = IDLE;
                        end else begin
                            frameBad  = 1'b1;
                            stateNext = BREAK;
                        end
                    end else begin
                        scNext = sc + SCW'(1);
                    end
                end
            end
            BREAK: begin
                if (rxS) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // A drain is skipped while a strobe is already out, so strobes never sit back to back.
    assign drain = pending && !hold && !rxDataRdy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            numRx      <= '0;
            rxDataRdy  <= 1'b0;
            framingErr <= 1'b0;
            overrun    <= 1'b0;
            pending    <= 1'b0;
            pendByte   <= '0;
        end else begin
            rxDataRdy  <= 1'b0;
            framingErr <= frameBad;
            overrun    <= 1'b0;
            if (drain) begin
                numRx     <= pendByte;
                rxDataRdy <= 1'b1;
                pending   <= 1'b0;
            end
            if (byteDone) begin
                if (pending && !drain) begin
                    overrun <= 1'b1;
                end else if (!hold && !drain && !rxDataRdy) begin
                    numRx     <= shreg;
                    rxDataRdy <= 1'b1;
                end else begin
                    pendByte <= shreg;
                    pending  <= 1'b1;
                end
            end
        end
    end

endmodule
